// File: rtl/igr_arb_prio_csr_v2_if.sv
// AVMM slave bus carrying CSR reads and writes into the ingress arbiter config block.
interface igr_arb_prio_csr_v2_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   avmm_address;
  logic                    avmm_read;
  logic [DATA_WIDTH-1:0]   avmm_readdata;
  logic                    avmm_readdata_valid;
  logic                    avmm_write;
  logic [DATA_WIDTH-1:0]   avmm_writedata;
  logic [DATA_WIDTH/8-1:0] avmm_byteenable;

  modport master (
    output avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
    input  avmm_readdata, avmm_readdata_valid
  );

  modport slave (
    input  avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
    output avmm_readdata, avmm_readdata_valid
  );
endinterface

// File: rtl/igr_arb_prio_csr_v2.sv
// Ingress arbiter CSR: shadow/active per-port priority+enable with idle-gated commit,
// plus saturating per-port grant counters.

module igr_arb_prio_csr_v2_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  // clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clr)             cnt <= '0;
    else if (inc && !(&cnt))    cnt <= cnt + 1'b1;
  end
endmodule

module igr_arb_prio_csr_v2 #(
  parameter int         BASE_ADDR  = 'h0,
  parameter int         MAX_ADDR   = 'h18,
  parameter int         ADDR_WIDTH = 8,
  parameter int         DATA_WIDTH = 32,
  parameter int         NUM_INTF   = 4,
  parameter int         CNT_WIDTH  = 16,
  parameter logic [3:0] RST_PRIO   = 4'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  igr_arb_prio_csr_v2_if.slave      avmm,
  input  logic                      arb_idle,
  input  logic [NUM_INTF-1:0]       arb_grant,
  output logic [NUM_INTF-1:0][3:0]  cfg_priority,
  output logic [NUM_INTF-1:0]       cfg_enable,
  output logic                      cfg_update_pend
);
  localparam int DW = DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0]   BASE_X         = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   MAX_X          = (ADDR_WIDTH+1)'(MAX_ADDR);
  localparam logic [ADDR_WIDTH-1:0] OFF_CTRL       = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OFF_SH_EN      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OFF_SH_PRIO_LO = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] OFF_SH_PRIO_HI = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] OFF_ACT_EN     = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] OFF_ACT_PRIO_LO= ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] OFF_ACT_PRIO_HI= ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] OFF_CNT        = ADDR_WIDTH'(8);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  logic [ADDR_WIDTH:0]               off_x;
  logic [ADDR_WIDTH-1:0]             off;
  logic                              in_rng;
  logic                              wr_hit;
  logic                              commit_wr;
  logic                              cnt_clr;
  logic                              act_load;
  state_t                            state_q, state_d;
  logic [NUM_INTF-1:0]               sh_en, act_en;
  logic [NUM_INTF-1:0][3:0]          sh_prio, act_prio;
  logic [NUM_INTF-1:0][CNT_WIDTH-1:0] grant_cnt;
  logic [DW-1:0]                     rd_word;
  logic [DW-1:0]                     rdata_q;
  logic                              rd_vld_q;
  logic                              unused_ok;

  // Borrow out of the subtraction flags addresses below the base.
  assign off_x     = {1'b0, avmm.avmm_address} - BASE_X;
  assign off       = off_x[ADDR_WIDTH-1:0];
  assign in_rng    = !off_x[ADDR_WIDTH] && (off_x < MAX_X);
  assign wr_hit    = avmm.avmm_write && in_rng;
  assign commit_wr = wr_hit && (off == OFF_CTRL) && avmm.avmm_byteenable[0] && avmm.avmm_writedata[0];
  assign cnt_clr   = wr_hit && (off == OFF_CTRL) && avmm.avmm_byteenable[1] && avmm.avmm_writedata[8];

  // Commit FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (commit_wr) state_d = S_PEND;
      S_PEND:  if (arb_idle)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_update_pend = (state_q == S_PEND);
    act_load        = (state_q == S_PEND) && arb_idle;
  end

  // Shadow / active config. Active samples the pre-write shadow on the load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_en    <= '1;
      act_en   <= '1;
      sh_prio  <= {NUM_INTF{RST_PRIO}};
      act_prio <= {NUM_INTF{RST_PRIO}};
    end else begin
      if (act_load) begin
        act_en   <= sh_en;
        act_prio <= sh_prio;
      end
      for (int n = 0; n < NUM_INTF; n++) begin
        if (wr_hit && (off == OFF_SH_EN) && avmm.avmm_byteenable[n/8])
          sh_en[n] <= avmm.avmm_writedata[n];
        if (wr_hit && (off == ((n < 8) ? OFF_SH_PRIO_LO : OFF_SH_PRIO_HI)) &&
            avmm.avmm_byteenable[(n%8)/2])
          sh_prio[n] <= avmm.avmm_writedata[4*(n%8) +: 4];
      end
    end
  end

  assign cfg_priority = act_prio;
  assign cfg_enable   = act_en;

  // Per-port grant counters
  igr_arb_prio_csr_v2_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt [NUM_INTF-1:0] (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (arb_grant),
    .cnt (grant_cnt)
  );

  function automatic logic [DW-1:0] prio_word(input logic [NUM_INTF-1:0][3:0] p, input logic hi);
    logic [DW-1:0] w;
    w = '0;
    for (int n = 0; n < NUM_INTF; n++)
      if ((n >= 8) == hi) w[4*(n%8) +: 4] = p[n];
    return w;
  endfunction

  always_comb begin
    rd_word = '0;
    if (in_rng) begin
      case (off)
        OFF_CTRL:        rd_word[1] = (state_q == S_PEND);
        OFF_SH_EN:       rd_word = DW'(sh_en);
        OFF_SH_PRIO_LO:  rd_word = prio_word(sh_prio, 1'b0);
        OFF_SH_PRIO_HI:  rd_word = prio_word(sh_prio, 1'b1);
        OFF_ACT_EN:      rd_word = DW'(act_en);
        OFF_ACT_PRIO_LO: rd_word = prio_word(act_prio, 1'b0);
        OFF_ACT_PRIO_HI: rd_word = prio_word(act_prio, 1'b1);
        default: ;
      endcase
      for (int n = 0; n < NUM_INTF; n++)
        if (off == OFF_CNT + ADDR_WIDTH'(n)) rd_word = DW'(grant_cnt[n]);
    end
  end

  // Read data is taken from register state before this cycle's write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_vld_q <= avmm.avmm_read;
      if (avmm.avmm_read) rdata_q <= rd_word;
    end
  end

  assign avmm.avmm_readdata       = rdata_q;
  assign avmm.avmm_readdata_valid = rd_vld_q;

  assign unused_ok = ^{avmm.avmm_writedata, avmm.avmm_byteenable, off_x};
endmodule

// File: tb/tb_igr_arb_prio_csr_v2.sv
// Bench for igr_arb_prio_csr_v2: directed vector table, hand sequences, and random
// traffic against a register-level reference model.
module tb_igr_arb_prio_csr_v2;
  localparam int NI = 4;

  logic              clk;
  logic              rst;
  logic              arb_idle;
  logic [NI-1:0]     arb_grant;
  logic [NI-1:0][3:0] cfg_priority;
  logic [NI-1:0]     cfg_enable;
  logic              cfg_update_pend;

  igr_arb_prio_csr_v2_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  igr_arb_prio_csr_v2 #(
    .BASE_ADDR('h0), .MAX_ADDR('h18), .ADDR_WIDTH(8), .DATA_WIDTH(32),
    .NUM_INTF(NI), .CNT_WIDTH(4), .RST_PRIO(4'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .avmm            (bus.slave),
    .arb_idle        (arb_idle),
    .arb_grant       (arb_grant),
    .cfg_priority    (cfg_priority),
    .cfg_enable      (cfg_enable),
    .cfg_update_pend (cfg_update_pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  // sampled DUT outputs
  logic        s_vld, s_pend;
  logic [31:0] s_rdata;
  logic [15:0] s_prio;
  logic [3:0]  s_en;

  // reference model state
  logic [3:0]  m_sh_en, m_act_en;
  int          m_sh_p[NI], m_act_p[NI], m_cnt[NI];
  logic        m_pend, m_vld;
  logic [31:0] m_rdata;

  function automatic logic [31:0] pack_prio(input int p[NI]);
    logic [31:0] w = 0;
    for (int n = 0; n < NI; n++) w = w | (32'(p[n]) << (4*n));
    return w;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a >= 'h18) return 32'h0;
    case (a)
      0:          return m_pend ? 32'h2 : 32'h0;
      1:          return 32'(m_sh_en);
      2:          return pack_prio(m_sh_p);
      4:          return 32'(m_act_en);
      5:          return pack_prio(m_act_p);
      8, 9, 10, 11: return 32'(m_cnt[a-8]);
      default:    return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic rd, input logic wr, input logic [7:0] a,
                            input logic [31:0] wd, input logic [3:0] be, input logic idle,
                            input logic [3:0] g);
    logic ok, apply, commit, clr, nxt_pend;
    logic [31:0] mask, old, nw;
    if (r) begin
      m_sh_en = 4'hF; m_act_en = 4'hF;
      for (int n = 0; n < NI; n++) begin m_sh_p[n] = 0; m_act_p[n] = 0; m_cnt[n] = 0; end
      m_pend = 0; m_vld = 0; m_rdata = 0;
      return;
    end
    ok = (a < 8'h18);
    m_vld = rd;
    if (rd) m_rdata = m_read(int'(a));
    apply  = m_pend && idle;
    commit = wr && ok && (a == 0) && be[0] && wd[0];
    clr    = wr && ok && (a == 0) && be[1] && wd[8];
    if (apply) begin
      m_act_en = m_sh_en;
      for (int n = 0; n < NI; n++) m_act_p[n] = m_sh_p[n];
    end
    if (wr && ok && (a == 1 || a == 2)) begin
      mask = 0;
      for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8*b));
      old = m_read(int'(a));
      nw  = (old & ~mask) | (wd & mask);
      if (a == 1) m_sh_en = nw[3:0];
      else for (int n = 0; n < NI; n++) m_sh_p[n] = int'((nw >> (4*n)) & 32'hF);
    end
    for (int n = 0; n < NI; n++) begin
      if (clr) m_cnt[n] = 0;
      else if (g[n] && m_cnt[n] < 15) m_cnt[n] = m_cnt[n] + 1;
    end
    nxt_pend = m_pend ? !idle : commit;
    m_pend = nxt_pend;
  endtask

  task automatic step(input logic r, input logic rd, input logic wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input logic idle,
                      input logic [3:0] g);
    rst = r; arb_idle = idle; arb_grant = g;
    bus.avmm_read = rd; bus.avmm_write = wr; bus.avmm_address = a;
    bus.avmm_writedata = wd; bus.avmm_byteenable = be;
    model_step(r, rd, wr, a, wd, be, idle, g);
    @(posedge clk);
    #1;
    s_vld = bus.avmm_readdata_valid; s_rdata = bus.avmm_readdata;
    s_prio = cfg_priority; s_en = cfg_enable; s_pend = cfg_update_pend;
  endtask

  task automatic idle_step(input logic idle, input logic [3:0] g);
    step(0, 0, 0, 8'h0, 32'h0, 4'h0, idle, g);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".vld"},   32'(s_vld),  32'(m_vld));
    chk({tag, ".rdata"}, s_rdata,     m_rdata);
    chk({tag, ".prio"},  32'(s_prio), 32'(pack_prio(m_act_p)));
    chk({tag, ".en"},    32'(s_en),   32'(m_act_en));
    chk({tag, ".pend"},  32'(s_pend), 32'(m_pend));
  endtask

  typedef struct {
    logic r, rd, wr; logic [7:0] a; logic [31:0] wd; logic [3:0] be; logic idle; logic [3:0] g;
    logic e_vld; logic [31:0] e_rd; logic [15:0] e_prio; logic [3:0] e_en; logic e_pend;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; arb_idle = 1'b0; arb_grant = '0;
    bus.avmm_read = 0; bus.avmm_write = 0; bus.avmm_address = 0;
    bus.avmm_writedata = 0; bus.avmm_byteenable = 0;

    //               r rd wr addr   wdata          be    idl g     vld rdata          prio      en    pend
    tbl.push_back('{1,1,0,8'h04,32'h0,         4'h0,0,4'h0, 0,32'h0,        16'h0000,4'hF,0}); // read in reset: no valid
    tbl.push_back('{1,0,0,8'h00,32'h0,         4'h0,0,4'h0, 0,32'h0,        16'h0000,4'hF,0});
    tbl.push_back('{0,1,0,8'h04,32'h0,         4'h0,0,4'h0, 1,32'hF,        16'h0000,4'hF,0});
    tbl.push_back('{0,1,0,8'h05,32'h0,         4'h0,0,4'h0, 1,32'h0,        16'h0000,4'hF,0});
    tbl.push_back('{0,0,1,8'h02,32'h4321,      4'hF,0,4'h0, 0,32'h0,        16'h0000,4'hF,0});
    tbl.push_back('{0,0,1,8'h00,32'h1,         4'h1,0,4'h0, 0,32'h0,        16'h0000,4'hF,1}); // commit, busy
    tbl.push_back('{0,0,0,8'h00,32'h0,         4'h0,0,4'h0, 0,32'h0,        16'h0000,4'hF,1});
    tbl.push_back('{0,1,0,8'h00,32'h0,         4'h0,0,4'h0, 1,32'h2,        16'h0000,4'hF,1}); // CTRL.PEND
    tbl.push_back('{0,0,0,8'h00,32'h0,         4'h0,1,4'h0, 0,32'h2,        16'h4321,4'hF,0}); // idle -> apply
    tbl.push_back('{0,1,0,8'h05,32'h0,         4'h0,0,4'h0, 1,32'h4321,     16'h4321,4'hF,0});
    tbl.push_back('{0,0,1,8'h02,32'hFFFF_FF65, 4'h1,0,4'h0, 0,32'h4321,     16'h4321,4'hF,0}); // lane 0 only
    tbl.push_back('{0,1,0,8'h02,32'h0,         4'h0,0,4'h0, 1,32'h4365,     16'h4321,4'hF,0});
    tbl.push_back('{0,1,0,8'h18,32'h0,         4'h0,0,4'h0, 1,32'h0,        16'h4321,4'hF,0}); // out of range
    tbl.push_back('{0,0,1,8'h18,32'hFFFF_FFFF, 4'hF,0,4'h0, 0,32'h0,        16'h4321,4'hF,0});
    tbl.push_back('{0,1,0,8'h02,32'h0,         4'h0,0,4'h0, 1,32'h4365,     16'h4321,4'hF,0});
    tbl.push_back('{0,1,0,8'h01,32'h0,         4'h0,0,4'h0, 1,32'hF,        16'h4321,4'hF,0});
    tbl.push_back('{0,1,1,8'h01,32'h0,         4'hF,0,4'h0, 1,32'hF,        16'h4321,4'hF,0}); // read sees pre-write
    tbl.push_back('{0,1,0,8'h01,32'h0,         4'h0,0,4'h0, 1,32'h0,        16'h4321,4'hF,0});
    tbl.push_back('{0,1,0,8'h07,32'h0,         4'h0,0,4'h0, 1,32'h0,        16'h4321,4'hF,0});
    tbl.push_back('{0,0,1,8'h00,32'h1,         4'h1,1,4'h0, 0,32'h0,        16'h4321,4'hF,1}); // idle ignored on commit
    tbl.push_back('{0,0,0,8'h00,32'h0,         4'h0,1,4'h0, 0,32'h0,        16'h4365,4'h0,0});
    tbl.push_back('{0,0,1,8'h00,32'h1,         4'h2,0,4'h0, 0,32'h0,        16'h4365,4'h0,0}); // wrong lane
    tbl.push_back('{0,1,0,8'h80,32'h0,         4'h0,0,4'h0, 1,32'h0,        16'h4365,4'h0,0});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].be, tbl[i].idle, tbl[i].g);
      chk($sformatf("t%0d.vld", i),   32'(s_vld),  32'(tbl[i].e_vld));
      chk($sformatf("t%0d.rdata", i), s_rdata,     tbl[i].e_rd);
      chk($sformatf("t%0d.prio", i),  32'(s_prio), 32'(tbl[i].e_prio));
      chk($sformatf("t%0d.en", i),    32'(s_en),   32'(tbl[i].e_en));
      chk($sformatf("t%0d.pend", i),  32'(s_pend), 32'(tbl[i].e_pend));
    end

    // grant counter saturation and clear-beats-grant
    for (int k = 0; k < 20; k++) idle_step(0, 4'b0010);
    step(0, 1, 0, 8'h09, 32'h0, 4'h0, 0, 4'h0);
    chk("cnt1_sat", s_rdata, 32'hF);
    step(0, 1, 0, 8'h08, 32'h0, 4'h0, 0, 4'h0);
    chk("cnt0_zero", s_rdata, 32'h0);
    step(0, 0, 1, 8'h00, 32'h100, 4'h2, 0, 4'b0010);
    step(0, 1, 0, 8'h09, 32'h0, 4'h0, 0, 4'h0);
    chk("cnt1_clr_vs_grant", s_rdata, 32'h0);
    chk("cnt1_clr_vld", 32'(s_vld), 32'h1);

    // reset while pending drops the commit
    step(0, 0, 1, 8'h02, 32'h7777, 4'hF, 0, 4'h0);
    step(0, 0, 1, 8'h00, 32'h1, 4'h1, 0, 4'h0);
    idle_step(0, 4'h0);
    chk("rstpend.pend_before", 32'(s_pend), 32'h1);
    step(1, 0, 0, 8'h00, 32'h0, 4'h0, 0, 4'h0);
    chk("rstpend.pend", 32'(s_pend), 32'h0);
    chk("rstpend.prio", 32'(s_prio), 32'h0);
    chk("rstpend.en",   32'(s_en),   32'hF);
    idle_step(1, 4'h0);
    idle_step(1, 4'h0);
    chk("rstpend.prio_after_idle", 32'(s_prio), 32'h0);
    chk("rstpend.pend_after_idle", 32'(s_pend), 32'h0);
    step(0, 1, 0, 8'h02, 32'h0, 4'h0, 0, 4'h0);
    chk("rstpend.sh_prio", s_rdata, 32'h0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic r, rd, wr, idle;
      logic [7:0] a;
      logic [31:0] wd;
      logic [3:0] be, g;
      r    = ($urandom_range(0, 99) == 0);
      rd   = $urandom_range(0, 1);
      wr   = $urandom_range(0, 1);
      a    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 'h1A));
      wd   = $urandom;
      wd[8] = ($urandom_range(0, 7) == 0);
      be   = 4'($urandom);
      idle = ($urandom_range(0, 3) == 0);
      g    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(r, rd, wr, a, wd, be, idle, g);
      chk_model($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
